// File: rtl/ram8x8_ctrl_pkg.sv
// Shared definitions for the RAM8x8 two-requester controller.
//   AW, DW    : address / data widths of the RAM8x8 macro
//   state_e   : controller state (init sweep, arbitration)
//   ID_A/ID_B : requester indices into the 2-bit req/gnt vectors
package ram8x8_ctrl_pkg;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  typedef enum logic {
    S_INIT = 1'b0,
    S_ARB  = 1'b1
  } state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests, bit ID_A = requester A, bit ID_B = requester B
//   en         : grants are suppressed while low
//   gnt[1:0]   : combinational grant, one-hot or zero
// The last-granted pointer resets to B so that A wins the first conflict.
module rr_arb2
  import ram8x8_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Conflict: favour whoever was not granted most recently.
        2'b11:   gnt = (last_q == ID_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt[ID_A]) begin
      last_d = ID_A;
    end else if (gnt[ID_B]) begin
      last_d = ID_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ID_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram8x8_arbiter.sv
// Controller sharing one RAM8x8 macro between requesters A and B.
// After reset it writes INIT_VAL to every word (one word per cycle), then
// arbitrates single-cycle accesses round-robin and steers read data back.
//   clk, rst_n                 : clock (shared with RAM8x8), async active-low reset
//   init_done                  : high from the first arbitration cycle until reset
//   req_x, we_x, addr_x, wdata_x : request, write enable, address, write data (x = a/b)
//   gnt_x                      : combinational grant; transfer on edge where req & gnt
//   rvalid_x, rdata_x          : read return, one cycle after a granted read
//   ram_addr, ram_d, ram_we    : RAM8x8 address / data-in / write enable
//   ram_q                      : RAM8x8 data-out, valid the cycle after the address
module ram8x8_arbiter #(
  parameter int unsigned       AW       = ram8x8_ctrl_pkg::AW,
  parameter int unsigned       DW       = ram8x8_ctrl_pkg::DW,
  parameter logic [DW-1:0]     INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_done,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  import ram8x8_ctrl_pkg::*;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          arb_en;

  assign req[ID_A] = req_a;
  assign req[ID_B] = req_b;
  assign arb_en    = (state_q == S_ARB);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (arb_en),
    .gnt   (gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = 2'b00;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_d    = '0;
    unique case (state_q)
      S_INIT: begin
        // Gate with rst_n so the macro sees no write strobe while held in reset.
        ram_we   = rst_n;
        ram_addr = cnt_q;
        ram_d    = rst_n ? INIT_VAL : '0;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == '1) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (gnt[ID_A]) begin
          ram_we         = we_a;
          ram_addr       = addr_a;
          ram_d          = wdata_a;
          rvalid_d[ID_A] = ~we_a;
        end else if (gnt[ID_B]) begin
          ram_we         = we_b;
          ram_addr       = addr_b;
          ram_d          = wdata_b;
          rvalid_d[ID_B] = ~we_b;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign init_done = (state_q == S_ARB);
  assign gnt_a     = gnt[ID_A];
  assign gnt_b     = gnt[ID_B];
  assign rvalid_a  = rvalid_q[ID_A];
  assign rvalid_b  = rvalid_q[ID_B];
  assign rdata_a   = rvalid_q[ID_A] ? ram_q : '0;
  assign rdata_b   = rvalid_q[ID_B] ? ram_q : '0;

endmodule

// File: doc/ram8x8_arbiter.md
# ram8x8_arbiter

Two-requester controller that shares one RAM8x8 macro (8 words × 8 bits, synchronous write, one-cycle read) between requesters A and B. After reset it sequences an initialization sweep that writes INIT_VAL to all words, then arbitrates single-cycle accesses round-robin and returns read data to the issuing requester. It sits directly in front of the RAM8x8 instance and owns its clk-domain D/addr/we pins.

## Interface
- AW, 3, address width (RAM depth 2^AW = 8)
- DW, 8, data width
- INIT_VAL, 8'h00, value written to every word during the init sweep
- clk  in  1  rising-edge clock, shared with RAM8x8
- rst_n  in  1  asynchronous active-low reset
- init_done  out  1  high once the init sweep completes; stays high until reset
- req_a / req_b  in  1  access request
- we_a / we_b  in  1  1 = write, 0 = read; qualified by req
- addr_a / addr_b  in  AW  word address
- wdata_a / wdata_b  in  DW  write data
- gnt_a / gnt_b  out  1  combinational grant; transfer occurs on the edge where req & gnt
- rvalid_a / rvalid_b  out  1  read data valid, one cycle after a granted read
- rdata_a / rdata_b  out  DW  read data; forced to 0 when the matching rvalid is low
- ram_addr  out  AW  to RAM8x8 addr
- ram_d  out  DW  to RAM8x8 D
- ram_we  out  1  to RAM8x8 we
- ram_q  in  DW  from RAM8x8 Q, valid the cycle after the address is presented

## Operation
- States: S_INIT, S_ARB. Reset → S_INIT, init counter = 0.
- S_INIT: ram_we = 1, ram_addr = counter, ram_d = INIT_VAL. Counter increments each cycle. On counter = 7, go to S_ARB next cycle. gnt_a = gnt_b = 0 throughout. S_ARB is entered exactly 8 cycles after rst_n deasserts. init_done rises on entry to S_ARB.
- S_ARB: at most one grant per cycle.
  - Only one req → grant it.
  - Both req → grant the requester not granted most recently.
  - last-granted pointer resets to B, so A wins the first conflict. The pointer updates only on a grant.
- Granted requester's we/addr/wdata are muxed onto ram_we/ram_addr/ram_d. With no grant, ram_we = 0 and ram_addr/ram_d hold 0.
- Granted read:
  - The rvalid bit for that requester is registered high for exactly the next cycle.
  - Its rdata = ram_q during that cycle. The other requester's rdata = 0.
- Granted write: no rvalid is produced.
- Requesters hold req and fields stable until granted. A held req with no grant is simply retried next cycle; there is no timeout.
- Back-to-back grants to the same requester are allowed when the other is idle.
- Read-after-write to the same address on consecutive cycles returns the newly written data.
- Reset mid-operation:
  - All outputs return to reset values immediately.
  - Any pending rvalid is dropped.
  - The init sweep restarts from word 0.

## Timing
- Reset values: init_done 0, gnt_a/b 0, rvalid_a/b 0, rdata_a/b 0, ram_we 0 while rst_n low, ram_addr 0, ram_d 0.
- Grant is combinational from req and the state/pointer registers. No pipeline bubble; 100% RAM utilization is possible.
- Read latency: grant edge N → rvalid and rdata valid during cycle N+1. A new grant may be issued in cycle N+1.
- Worst-case wait under continuous contention: 1 cycle.

## Structure
- Shared package/header ram8x8_ctrl_pkg: AW, DW, state encoding (S_INIT, S_ARB), requester-ID constants (ID_A = 0, ID_B = 1).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], en.
  - Outputs: gnt[1:0], one-hot or zero.
  - Owns the last-granted pointer.
- The top level holds the FSM, init counter, datapath muxes, and rvalid/owner register.

## Test plan
- Reset release → init_done rises 8 cycles later, with ram_we high for exactly 8 cycles at addresses 0..7 and ram_d = 8'h00. A read of addr 5 then returns 8'h00.
- A writes 8'hA5 to addr 3, then B reads addr 3 → gnt_b next cycle, and rvalid_b one cycle after that with rdata_b = 8'hA5, rdata_a = 0.
- Both req continuously after init (A reads addr 1, B reads addr 2) → grants alternate A, B, A, B, starting with A. Each rvalid appears one cycle after its own grant.
- Write 8'h3C to addr 7 by A, then immediately a read of addr 7 by A on the next cycle → rvalid_a with rdata_a = 8'h3C.
- req_a asserted during S_INIT → gnt_a stays 0 until init_done, then is granted on the first S_ARB cycle.
- Assert rst_n low while rvalid_b is pending → rvalid_b, gnt_a/b, and init_done drop asynchronously. After release, the sweep reruns and words previously written read back as INIT_VAL.
